// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-button synchroniser, debouncer and press/release/repeat pulse generator
module button_debounce #(
  parameter int NUM_BUTTONS     = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = 24,
  parameter int DEBOUNCE_CYCLES = 240_000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 12_000_000,
  parameter int REPEAT_PERIOD   = 6_000_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] push_button,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release
);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic [NUM_BUTTONS-1:0] IDLE_RAW    = {NUM_BUTTONS{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0]       DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]       DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]       PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  if ((DEBOUNCE_CYCLES < 1) || (longint'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) ||
      (REPEAT_EN && ((REPEAT_DELAY < 1) || (longint'(REPEAT_DELAY) >= (64'd1 << CNT_W)) ||
                     (REPEAT_PERIOD < 1) || (longint'(REPEAT_PERIOD) >= (64'd1 << CNT_W))))) begin : g_bad_params
    $error("button_debounce: counter parameters out of range for CNT_W");
  end

  logic [NUM_BUTTONS-1:0] sync1, sync2, s;
  logic [NUM_BUTTONS-1:0] first_rep;
  logic [CNT_W-1:0]       dcnt [NUM_BUTTONS];
  logic [CNT_W-1:0]       rcnt [NUM_BUTTONS];
  state_t                 state [NUM_BUTTONS];

  // s is the synchronised button, normalised so 1 always means pressed
  assign s = sync2 ^ IDLE_RAW;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1       <= IDLE_RAW;
      sync2       <= IDLE_RAW;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      first_rep   <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        dcnt[i]  <= '0;
        rcnt[i]  <= '0;
        state[i] <= RELEASED;
      end
    end else begin
      sync1 <= push_button;
      sync2 <= sync1;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        btn_press[i]   <= 1'b0;
        btn_release[i] <= 1'b0;
        case (state[i])
          RELEASED, PRESS_WAIT: begin
            rcnt[i] <= '0;
            if (!s[i]) begin
              state[i] <= RELEASED;
              dcnt[i]  <= '0;
            end else if (dcnt[i] == DEB_LAST) begin
              state[i]     <= PRESSED;
              btn_level[i] <= 1'b1;
              btn_press[i] <= 1'b1;
              dcnt[i]      <= '0;
              first_rep[i] <= 1'b1;
            end else begin
              state[i] <= PRESS_WAIT;
              dcnt[i]  <= dcnt[i] + 1'b1;
            end
          end
          default: begin
            // A completed release takes priority over any repeat due in the same cycle
            if (!s[i] && (dcnt[i] == DEB_LAST)) begin
              state[i]       <= RELEASED;
              btn_level[i]   <= 1'b0;
              btn_release[i] <= 1'b1;
              dcnt[i]        <= '0;
              rcnt[i]        <= '0;
            end else begin
              if (s[i]) begin
                state[i] <= PRESSED;
                dcnt[i]  <= '0;
              end else begin
                state[i] <= RELEASE_WAIT;
                dcnt[i]  <= dcnt[i] + 1'b1;
              end
              if (REPEAT_EN) begin
                if (rcnt[i] == (first_rep[i] ? DELAY_LAST : PERIOD_LAST)) begin
                  btn_press[i] <= 1'b1;
                  rcnt[i]      <= '0;
                  first_rep[i] <= 1'b0;
                end else begin
                  rcnt[i] <= rcnt[i] + 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - table-driven and scoreboard bench for button_debounce
module tb_button_debounce;

  localparam int LAT = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] push_button = 4'hF;
  logic [3:0] btn_level, btn_press, btn_release;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] release_;
    logic [3:0] level;
  } ev_t;

  typedef struct {
    string      name;
    logic [3:0] mask;
    int         hold;
    logic [3:0] exp_press;
    logic [3:0] exp_release;
  } vec_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  button_debounce #(
    .NUM_BUTTONS(4), .ACTIVE_LOW(1'b1), .CNT_W(24), .DEBOUNCE_CYCLES(8),
    .REPEAT_EN(1'b1), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .clock(clock), .reset(reset), .push_button(push_button),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock)
    if ((btn_press != 4'b0) || (btn_release != 4'b0))
      obs_q.push_back('{cyc, btn_press, btn_release, btn_level});

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_ev(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    exp_q.push_back('{c, p, r, l});
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_events(input string name);
    ev_t e, o;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL %s event count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      tests++;
      if (exp_q.size() == 0) begin
        o = obs_q.pop_front();
        failed++;
        $display("FAIL %s unexpected: got cyc=%0d press=%b release=%b level=%b expected none",
                 name, o.cyc, o.press, o.release_, o.level);
      end else if (obs_q.size() == 0) begin
        e = exp_q.pop_front();
        failed++;
        $display("FAIL %s missing: got none expected cyc=%0d press=%b release=%b level=%b",
                 name, e.cyc, e.press, e.release_, e.level);
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o != e) begin
          failed++;
          $display("FAIL %s: got cyc=%0d press=%b release=%b level=%b expected cyc=%0d press=%b release=%b level=%b",
                   name, o.cyc, o.press, o.release_, o.level, e.cyc, e.press, e.release_, e.level);
        end
      end
    end
  endtask

  initial begin
    vec_t vecs[5];
    int   n;
    vecs[0] = '{"b0_single_press",  4'b0001, 15, 4'b0001, 4'b0001};
    vecs[1] = '{"b2_short_glitch",  4'b0100,  5, 4'b0000, 4'b0000};
    vecs[2] = '{"b1_hold_one_less", 4'b0010,  7, 4'b0000, 4'b0000};
    vecs[3] = '{"b1_hold_exact",    4'b0010,  8, 4'b0010, 4'b0010};
    vecs[4] = '{"b0_b3_together",   4'b1001, 15, 4'b1001, 4'b1001};

    step(3);
    chk("reset_level", btn_level, 4'b0);
    chk("reset_press", btn_press, 4'b0);
    chk("reset_release", btn_release, 4'b0);
    reset = 1'b0;
    step(3);

    foreach (vecs[k]) begin
      n = cyc;
      push_button = ~vecs[k].mask;
      if (vecs[k].exp_press != 4'b0) begin
        expect_ev(n + LAT, vecs[k].exp_press, 4'b0, vecs[k].exp_press);
        expect_ev(n + vecs[k].hold + LAT, 4'b0, vecs[k].exp_release, 4'b0);
      end
      step(vecs[k].hold);
      push_button = 4'hF;
      step(LAT + 6);
      check_events(vecs[k].name);
    end

    // bounce 0,1,0,1 at 3-cycle intervals, then stable pressed
    push_button[0] = 1'b0; step(3);
    push_button[0] = 1'b1; step(3);
    push_button[0] = 1'b0; step(3);
    push_button[0] = 1'b1; step(3);
    push_button[0] = 1'b0;
    n = cyc;
    expect_ev(n + LAT, 4'b0001, 4'b0, 4'b0001);
    step(15);
    push_button[0] = 1'b1;
    expect_ev(n + 15 + LAT, 4'b0, 4'b0001, 4'b0);
    step(LAT + 6);
    check_events("bounce");

    // hold-to-repeat; the repeat due at +60 after the press pulse collides with the release
    n = cyc;
    push_button[0] = 1'b0;
    expect_ev(n + LAT, 4'b0001, 4'b0, 4'b0001);
    for (int k = 0; k < 8; k++) expect_ev(n + LAT + 20 + 5 * k, 4'b0001, 4'b0, 4'b0001);
    expect_ev(n + 60 + LAT, 4'b0, 4'b0001, 4'b0);
    step(60);
    push_button[0] = 1'b1;
    step(LAT + 10);
    check_events("repeat");

    // reset while pressed, button kept held through reset
    n = cyc;
    push_button[1] = 1'b0;
    expect_ev(n + LAT, 4'b0010, 4'b0, 4'b0010);
    step(LAT + 4);
    chk("held_level_before_reset", btn_level, 4'b0010);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_level", btn_level, 4'b0);
    chk("async_reset_press", btn_press, 4'b0);
    chk("async_reset_release", btn_release, 4'b0);
    step(3);
    reset = 1'b0;
    n = cyc;
    expect_ev(n + LAT, 4'b0010, 4'b0, 4'b0010);
    step(15);
    push_button[1] = 1'b1;
    expect_ev(n + 15 + LAT, 4'b0, 4'b0010, 4'b0);
    step(LAT + 6);
    check_events("reset_held");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
